wave_sequencer: RTL and testbench
=================================

WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 Parameter NUM_SEG, default 8, number of segment table entries (power of two, 2..16); SW = log2(NUM_SEG).
REQ-002 clk  input  1  system clock; all flops on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 cfg_we  input  1  segment table write strobe.
REQ-005 cfg_addr  input  SW  segment index written.
REQ-006 cfg_sel  input  2  segment waveform select (00 nco, 01 chirp, 10 sawtooth, 11 pulse).
REQ-007 cfg_freq  input  32  segment frequency control word.
REQ-008 cfg_duty  input  32  segment pulse duty-cycle word.
REQ-009 cfg_len  input  32  segment duration in clk cycles.
REQ-010 last_seg  input  SW  index of final segment in sequence.
REQ-011 loop_en  input  1  restart at segment 0 after last_seg.
REQ-012 start  input  1  begin sequence (level-sampled).
REQ-013 stop  input  1  abort sequence.
REQ-014 pause  input  1  freeze sequence while high.
REQ-015 wave_sel  output  2  registered waveform select to generator.
REQ-016 freq_ctrl  output  32  registered frequency control word to generator.
REQ-017 pulse_duty_cycle  output  32  registered duty word to generator.
REQ-018 busy  output  1  high in PLAY or PAUSE.
REQ-019 seg_idx  output  SW  index of segment currently driven.
REQ-020 seg_done  output  1  one-cycle pulse, final cycle of each segment.
REQ-021 seq_done  output  1  one-cycle pulse on natural completion.

Function
REQ-022 States IDLE, PLAY, PAUSE; table is a flop array read combinationally by seg_idx/next index.
REQ-023 IDLE & start & !stop: on that edge load entry 0 into outputs, seg_idx=0, remaining=max(len0,1), go PLAY.
REQ-024 PLAY: remaining decrements each cycle; cfg_len=0 treated as 1 (no zero-length segment).
REQ-025 Segment k outputs visible for exactly max(len_k,1) cycles; no gap cycles between segments.
REQ-026 seg_done high combinationally-registered-equivalent on the cycle remaining==1 in PLAY (registered output, aligned to that cycle).
REQ-027 End of segment, seg_idx<last_seg: next edge loads entry seg_idx+1.
REQ-028 End of segment, seg_idx>=last_seg, loop_en=1: next edge loads entry 0, stays PLAY, no seq_done.
REQ-029 End of segment, seg_idx>=last_seg, loop_en=0: next edge -> IDLE, outputs zeroed, seq_done=1 for exactly one cycle.
REQ-030 PLAY & pause: -> PAUSE; counter and outputs frozen; seg_done suppressed; !pause returns to PLAY continuing count.
REQ-031 stop in PLAY or PAUSE: next edge -> IDLE, outputs zeroed, seg_idx=0, no seq_done, no seg_done.
REQ-032 Priority: stop > pause > segment advance; start ignored when busy.
REQ-033 cfg_we accepted in any state; write to an entry takes effect only when that entry is next loaded; current outputs unaffected.
REQ-034 last_seg and loop_en sampled at each segment end, not latched at start.
REQ-035 In IDLE wave_sel, freq_ctrl, pulse_duty_cycle are 0.

Reset
REQ-036 rst asserted: state IDLE, all outputs 0, seg_idx 0, counter 0, table entries 0, effective immediately (async).
REQ-037 rst deasserted: first active edge may accept start.

Structure
REQ-038 Shared package wavegen_pkg holds state enum, wave_sel encodings, NUM_SEG default, 32-bit control-word width constant.
REQ-039 One sub-module seg_table: NUM_SEG x 98-bit register file, one write port, two combinational read ports (current, next).

Verification
REQ-040 seg0 {10, freq 0x0100_0000, len 4}, seg1 {11, duty 0x8000_0000, len 2}, last_seg 1, loop 0, start -> sawtooth 4 cycles, pulse 2 cycles, seg_done at cycles 4 and 6, seq_done cycle 7, busy falls cycle 7.
REQ-041 Same table, loop_en=1 -> pattern repeats 4,2,4,2 with no gap; seq_done never asserts; stop -> outputs 0 next cycle.
REQ-042 len=0 on seg0 -> seg0 driven exactly 1 cycle.
REQ-043 pause held 5 cycles mid seg0 (len 8) -> seg0 visible 13 cycles total, single seg_done.
REQ-044 stop and pause same cycle -> IDLE next edge; rst asserted mid-PLAY -> outputs 0 without waiting for clk.
REQ-045 cfg_we rewriting seg1 during seg0 -> new seg1 values driven at transition; rewriting seg0 during seg0 -> no output change.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared types and constants for the waveform segment sequencer.
// Holds the FSM state encoding, generator waveform selects and the segment table entry layout.
package wavegen_pkg;

  localparam int NUM_SEG_DEF = 8;
  localparam int CW          = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WAVE_NCO   = 2'b00,
    WAVE_CHIRP = 2'b01,
    WAVE_SAW   = 2'b10,
    WAVE_PULSE = 2'b11
  } wave_t;

  // 98-bit table entry: select, frequency word, duty word, duration
  typedef struct packed {
    wave_t         sel;
    logic [CW-1:0] freq;
    logic [CW-1:0] duty;
    logic [CW-1:0] len;
  } seg_entry_t;

  // A zero duration still plays the segment for one cycle
  function automatic logic [CW-1:0] eff_len(input logic [CW-1:0] len);
    return (len == '0) ? CW'(1) : len;
  endfunction

endpackage

// File: rtl/wave_sequencer_if.sv
// Configuration, control and generator-facing signals of the wave sequencer.
// The master side programs and controls the sequencer; the slave side is the sequencer itself.
interface wave_sequencer_if #(
  parameter int SW = 3
) ();
  import wavegen_pkg::*;

  logic          cfg_we;
  logic [SW-1:0] cfg_addr;
  logic [1:0]    cfg_sel;
  logic [CW-1:0] cfg_freq;
  logic [CW-1:0] cfg_duty;
  logic [CW-1:0] cfg_len;
  logic [SW-1:0] last_seg;
  logic          loop_en;
  logic          start;
  logic          stop;
  logic          pause;

  logic [1:0]    wave_sel;
  logic [CW-1:0] freq_ctrl;
  logic [CW-1:0] pulse_duty_cycle;
  logic          busy;
  logic [SW-1:0] seg_idx;
  logic          seg_done;
  logic          seq_done;

  modport master (
    output cfg_we, cfg_addr, cfg_sel, cfg_freq, cfg_duty, cfg_len,
    output last_seg, loop_en, start, stop, pause,
    input  wave_sel, freq_ctrl, pulse_duty_cycle, busy, seg_idx, seg_done, seq_done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sel, cfg_freq, cfg_duty, cfg_len,
    input  last_seg, loop_en, start, stop, pause,
    output wave_sel, freq_ctrl, pulse_duty_cycle, busy, seg_idx, seg_done, seq_done
  );

endinterface

// File: rtl/seg_table.sv
// Segment parameter register file: one write port, two combinational read ports.
// Entries clear on reset so an unprogrammed segment drives all-zero controls.
module seg_table
  import wavegen_pkg::*;
#(
  parameter int NUM_SEG = NUM_SEG_DEF,
  parameter int SW      = $clog2(NUM_SEG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [SW-1:0] waddr,
  input  seg_entry_t    wdata,
  input  logic [SW-1:0] raddr_a,
  output seg_entry_t    rdata_a,
  input  logic [SW-1:0] raddr_b,
  output seg_entry_t    rdata_b
);

  seg_entry_t mem_reg [NUM_SEG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_reg[raddr_a];
  assign rdata_b = mem_reg[raddr_b];

endmodule

// File: rtl/wave_sequencer.sv
// Plays a programmable list of waveform segments, driving registered select/frequency/duty
// words to a waveform generator with no gap cycles between segments.
module wave_sequencer
  import wavegen_pkg::*;
#(
  parameter int NUM_SEG = NUM_SEG_DEF,
  parameter int SW      = $clog2(NUM_SEG)
) (
  input logic            clk,
  input logic            rst,
  wave_sequencer_if.slave bus
);

  state_t        state_reg, state_next;
  logic [SW-1:0] seg_idx_reg, seg_idx_next;
  logic [CW-1:0] remaining_reg, remaining_next;
  wave_t         wave_sel_reg, wave_sel_next;
  logic [CW-1:0] freq_reg, freq_next;
  logic [CW-1:0] duty_reg, duty_next;
  logic          seg_done_reg, seg_done_next;
  logic          seq_done_reg, seq_done_next;

  seg_entry_t    wr_entry;
  seg_entry_t    head_entry;
  seg_entry_t    succ_entry;
  seg_entry_t    load_entry;
  logic          load;
  logic          clear;

  assign wr_entry = '{sel: wave_t'(bus.cfg_sel), freq: bus.cfg_freq,
                      duty: bus.cfg_duty, len: bus.cfg_len};

  // Port a always serves restarts from entry 0, port b the successor of the playing segment
  seg_table #(
    .NUM_SEG (NUM_SEG),
    .SW      (SW)
  ) u_seg_table (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.cfg_we),
    .waddr   (bus.cfg_addr),
    .wdata   (wr_entry),
    .raddr_a ('0),
    .rdata_a (head_entry),
    .raddr_b (seg_idx_reg + SW'(1)),
    .rdata_b (succ_entry)
  );

  always_comb begin
    state_next     = state_reg;
    seg_idx_next   = seg_idx_reg;
    remaining_next = remaining_reg;
    wave_sel_next  = wave_sel_reg;
    freq_next      = freq_reg;
    duty_next      = duty_reg;
    seq_done_next  = 1'b0;
    load           = 1'b0;
    clear          = 1'b0;
    load_entry     = head_entry;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          load         = 1'b1;
          seg_idx_next = '0;
          state_next   = ST_PLAY;
        end
      end
      ST_PLAY, ST_PAUSE: begin
        if (bus.stop) begin
          clear = 1'b1;
        end else if (bus.pause) begin
          state_next = ST_PAUSE;
        end else begin
          state_next = ST_PLAY;
          if (remaining_reg > CW'(1)) begin
            remaining_next = remaining_reg - CW'(1);
          end else if (seg_idx_reg < bus.last_seg) begin
            load         = 1'b1;
            load_entry   = succ_entry;
            seg_idx_next = seg_idx_reg + SW'(1);
          end else if (bus.loop_en) begin
            load         = 1'b1;
            seg_idx_next = '0;
          end else begin
            clear         = 1'b1;
            seq_done_next = 1'b1;
          end
        end
      end
      default: begin
        clear = 1'b1;
      end
    endcase

    if (load) begin
      wave_sel_next  = load_entry.sel;
      freq_next      = load_entry.freq;
      duty_next      = load_entry.duty;
      remaining_next = eff_len(load_entry.len);
    end

    if (clear) begin
      state_next     = ST_IDLE;
      seg_idx_next   = '0;
      remaining_next = '0;
      wave_sel_next  = WAVE_NCO;
      freq_next      = '0;
      duty_next      = '0;
    end

    // Registered so it lines up with the cycle whose remaining count is 1
    seg_done_next = (state_next == ST_PLAY) && (remaining_next == CW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      seg_idx_reg   <= '0;
      remaining_reg <= '0;
      wave_sel_reg  <= WAVE_NCO;
      freq_reg      <= '0;
      duty_reg      <= '0;
      seg_done_reg  <= 1'b0;
      seq_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      seg_idx_reg   <= seg_idx_next;
      remaining_reg <= remaining_next;
      wave_sel_reg  <= wave_sel_next;
      freq_reg      <= freq_next;
      duty_reg      <= duty_next;
      seg_done_reg  <= seg_done_next;
      seq_done_reg  <= seq_done_next;
    end
  end

  assign bus.wave_sel         = wave_sel_reg;
  assign bus.freq_ctrl        = freq_reg;
  assign bus.pulse_duty_cycle = duty_reg;
  assign bus.busy             = (state_reg != ST_IDLE);
  assign bus.seg_idx          = seg_idx_reg;
  assign bus.seg_done         = seg_done_reg;
  assign bus.seq_done         = seq_done_reg;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: each step drives inputs, then checks the full output
// vector against hand-derived values one cycle at a time.
module tb_wave_sequencer;
  import wavegen_pkg::*;

  localparam int NSEG = 8;
  localparam int SWB  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wave_sequencer_if #(.SW(SWB)) bus ();

  wave_sequencer #(
    .NUM_SEG (NSEG),
    .SW      (SWB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output vector: {wave_sel, freq, duty, seg_idx, busy, seg_done, seq_done}
  task automatic chk_out(input string tag, input logic [1:0] sel, input logic [31:0] f,
                         input logic [31:0] d, input logic [SWB-1:0] idx, input logic b,
                         input logic sd, input logic qd);
    chk(tag,
        {56'h0, bus.wave_sel, bus.freq_ctrl, bus.pulse_duty_cycle, bus.seg_idx,
         bus.busy, bus.seg_done, bus.seq_done},
        {56'h0, sel, f, d, idx, b, sd, qd});
  endtask

  task automatic write_seg(input logic [SWB-1:0] a, input logic [1:0] s, input logic [31:0] f,
                           input logic [31:0] d, input logic [31:0] l);
    bus.cfg_addr = a;
    bus.cfg_sel  = s;
    bus.cfg_freq = f;
    bus.cfg_duty = d;
    bus.cfg_len  = l;
    bus.cfg_we   = 1'b1;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_sel  = '0;
    bus.cfg_freq = '0;
    bus.cfg_duty = '0;
    bus.cfg_len  = '0;
    bus.last_seg = '0;
    bus.loop_en  = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;

    // Reset asserted between clock edges must clear outputs immediately
    #1 rst = 1'b1;
    #1 chk_out("reset", 2'b00, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Two-segment sequence, no loop
    write_seg(3'd0, WAVE_SAW,   32'h0100_0000, 32'h0,         32'd4);
    write_seg(3'd1, WAVE_PULSE, 32'h0,         32'h8000_0000, 32'd2);
    bus.last_seg = 3'd1;
    bus.loop_en  = 1'b0;
    go();
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4)
        chk_out($sformatf("basic_c%0d", c), WAVE_SAW, 32'h0100_0000, 32'h0, 3'd0, 1'b1, c == 4, 1'b0);
      else if (c <= 6)
        chk_out($sformatf("basic_c%0d", c), WAVE_PULSE, 32'h0, 32'h8000_0000, 3'd1, 1'b1, c == 6, 1'b0);
      else
        chk_out($sformatf("basic_c%0d", c), WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    chk_out("basic_after", WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Looping playback, then stop
    bus.loop_en = 1'b1;
    go();
    for (int c = 1; c <= 12; c++) begin
      int pos;
      pos = (c - 1) % 6;
      if (pos < 4)
        chk_out($sformatf("loop_c%0d", c), WAVE_SAW, 32'h0100_0000, 32'h0, 3'd0, 1'b1, pos == 3, 1'b0);
      else
        chk_out($sformatf("loop_c%0d", c), WAVE_PULSE, 32'h0, 32'h8000_0000, 3'd1, 1'b1, pos == 5, 1'b0);
      if (c == 12) bus.stop = 1'b1;
      tick();
    end
    chk_out("loop_stop", WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
    tick();

    // Zero-length segment plays one cycle
    write_seg(3'd0, WAVE_SAW, 32'h0100_0000, 32'h0, 32'd0);
    go();
    for (int c = 1; c <= 4; c++) begin
      if (c == 1)
        chk_out($sformatf("zlen_c%0d", c), WAVE_SAW, 32'h0100_0000, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
      else if (c <= 3)
        chk_out($sformatf("zlen_c%0d", c), WAVE_PULSE, 32'h0, 32'h8000_0000, 3'd1, 1'b1, c == 3, 1'b0);
      else
        chk_out($sformatf("zlen_c%0d", c), WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
    end

    // Pause held for 5 cycles in an 8-cycle segment stretches it to 13
    write_seg(3'd0, WAVE_SAW, 32'h0100_0000, 32'h0, 32'd8);
    bus.last_seg = 3'd0;
    go();
    for (int c = 1; c <= 14; c++) begin
      if (c <= 13)
        chk_out($sformatf("pause_c%0d", c), WAVE_SAW, 32'h0100_0000, 32'h0, 3'd0, 1'b1, c == 13, 1'b0);
      else
        chk_out($sformatf("pause_c%0d", c), WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
      bus.pause = (c >= 3 && c <= 7);
      tick();
    end
    bus.pause = 1'b0;

    // Stop wins over pause in the same cycle
    go();
    chk_out("sp_c1", WAVE_SAW, 32'h0100_0000, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    bus.stop  = 1'b1;
    bus.pause = 1'b1;
    tick();
    chk_out("sp_idle", WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    tick();

    // Reset mid-play clears outputs without a clock edge, and empties the table
    go();
    chk_out("arst_play", WAVE_SAW, 32'h0100_0000, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("arst_async", WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    go();
    chk_out("arst_tbl_c1", WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("arst_tbl_c2", WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // Rewrites during play; start held high while busy is ignored
    write_seg(3'd0, WAVE_NCO,   32'h11, 32'h22, 32'd4);
    write_seg(3'd1, WAVE_CHIRP, 32'h33, 32'h44, 32'd2);
    bus.last_seg = 3'd1;
    bus.start    = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4)
        chk_out($sformatf("rw_c%0d", c), WAVE_NCO, 32'h11, 32'h22, 3'd0, 1'b1, c == 4, 1'b0);
      else if (c <= 7)
        chk_out($sformatf("rw_c%0d", c), WAVE_PULSE, 32'h55, 32'h66, 3'd1, 1'b1, c == 7, 1'b0);
      else
        chk_out($sformatf("rw_c%0d", c), WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
      bus.start  = (c < 8);
      bus.cfg_we = 1'b0;
      if (c == 1) begin
        bus.cfg_addr = 3'd1; bus.cfg_sel = WAVE_PULSE; bus.cfg_freq = 32'h55;
        bus.cfg_duty = 32'h66; bus.cfg_len = 32'd3; bus.cfg_we = 1'b1;
      end else if (c == 2) begin
        bus.cfg_addr = 3'd0; bus.cfg_sel = WAVE_SAW; bus.cfg_freq = 32'h77;
        bus.cfg_duty = 32'h88; bus.cfg_len = 32'd5; bus.cfg_we = 1'b1;
      end
      tick();
    end
    bus.start = 1'b0;
    chk_out("rw_after", WAVE_NCO, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
